// File: rtl/pcie_datalink_pkg.sv
// Shared data-link-layer definitions: DLLP transmit arbiter state encoding,
// DLLP source indices and the default UpdateFC period.
package pcie_datalink_pkg;

   // Arbiter FSM: ST_ARB picks a winner, ST_XFER forwards one whole packet.
   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_XFER = 1'b1
   } dllp_arb_state_e;

   // Requester indices on the DLLP transmit stream (0 = highest priority).
   localparam int DllpSrcAckNak = 0;
   localparam int DllpSrcFc     = 1;
   localparam int DllpSrcPm     = 2;

   // Cycles between periodic UpdateFC requests once FC init has completed.
   localparam logic [15:0] UpdateFcPeriodDefault = 16'd3000;

   // Width of each per-source packet counter in the optional statistics.
   localparam int DllpStatsWidth = 16;

endpackage

// File: rtl/pcie_fc_update_timer.sv
// Periodic UpdateFC request timer. Counts while FC init is complete, pulses
// update_fc_req_o for one cycle when the count reaches UPDATE_PERIOD-1, and
// restarts whenever the FC generator has just finished sending a DLLP (that
// DLLP already refreshed the credits, so the pending pulse is dropped).
module pcie_fc_update_timer
   import pcie_datalink_pkg::*;
#(
   parameter logic [15:0] UPDATE_PERIOD = UpdateFcPeriodDefault
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic fc_init_done_i,
   input  logic fc_last_beat_i,
   output logic update_fc_req_o
);

   logic [15:0] timer_q;
   logic [15:0] timer_d;
   logic        wrap;

   // Next timer value and request pulse; FC traffic restart beats the pulse.
   always_comb begin
      wrap            = (timer_q == (UPDATE_PERIOD - 16'd1));
      timer_d         = timer_q + 16'd1;
      update_fc_req_o = 1'b0;
      if (!fc_init_done_i) begin
         timer_d = '0;
      end else if (fc_last_beat_i) begin
         timer_d = '0;
      end else if (wrap) begin
         timer_d         = '0;
         update_fc_req_o = 1'b1;
      end
   end

   // Timer register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-atomic DLLP transmit arbiter. Shares one AXI-stream between NUM_SRC
// DLLP generators using fixed priority (index 0 highest) with anti-starvation
// promotion, and owns the periodic UpdateFC request timer.
// Optional build macro DLLP_ARB_STATS_EN adds per-source completed-packet
// counters on stats_o.
module pcie_dllp_tx_arbiter
   import pcie_datalink_pkg::*;
#(
   parameter int          DATA_WIDTH    = 32,
   parameter int          KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int          USER_WIDTH    = 3,
   parameter int          NUM_SRC       = 3,
   parameter int          STARVE_LIMIT  = 4,
   parameter int          FC_SRC_IDX    = DllpSrcFc,
   parameter logic [15:0] UPDATE_PERIOD = UpdateFcPeriodDefault
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_SRC*KEEP_WIDTH-1:0]  s_axis_tkeep,
   input  logic [NUM_SRC-1:0]             s_axis_tvalid,
   input  logic [NUM_SRC-1:0]             s_axis_tlast,
   input  logic [NUM_SRC*USER_WIDTH-1:0]  s_axis_tuser,
   output logic [NUM_SRC-1:0]             s_axis_tready,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   output logic [USER_WIDTH-1:0]          m_axis_tuser,
   input  logic                           m_axis_tready,
   input  logic                           fc_init_done_i,
   output logic                           update_fc_req_o,
   output logic [NUM_SRC-1:0]             grant_o
`ifdef DLLP_ARB_STATS_EN
   ,
   output logic [NUM_SRC*DllpStatsWidth-1:0] stats_o
`endif
);

   // Starvation counters saturate at STARVE_LIMIT, so they need to hold it.
   localparam int             CntW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

   dllp_arb_state_e state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [CntW-1:0]    starve_q [NUM_SRC];
   logic [CntW-1:0]    starve_d [NUM_SRC];

   logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
   logic [KEEP_WIDTH-1:0] src_keep [NUM_SRC];
   logic [USER_WIDTH-1:0] src_user [NUM_SRC];
   logic [NUM_SRC-1:0]    starved;
   logic [NUM_SRC-1:0]    win_oh;
   logic                  beat;
   logic                  last_beat;
   logic                  fc_last_beat;

   // Unpack the per-source slices and flag sources due for promotion.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_keep[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign src_user[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
      assign starved[gi]  = s_axis_tvalid[gi] && (starve_q[gi] >= StarveMax);
   end

   // Winner: lowest-index starved requester, else lowest-index requester.
   always_comb begin
      logic found;
      win_oh = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (starved[i] && !found) begin
            win_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (s_axis_tvalid[i] && !found) begin
            win_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   // Output mux: combinational from the granted source while in ST_XFER.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state_q == ST_XFER) begin
         s_axis_tready = grant_q & {NUM_SRC{m_axis_tready}};
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
               m_axis_tdata  = src_data[i];
               m_axis_tkeep  = src_keep[i];
               m_axis_tuser  = src_user[i];
               m_axis_tvalid = s_axis_tvalid[i];
               m_axis_tlast  = s_axis_tlast[i];
            end
         end
      end
   end

   assign beat         = m_axis_tvalid && m_axis_tready;
   assign last_beat    = beat && m_axis_tlast;
   assign fc_last_beat = last_beat && grant_q[FC_SRC_IDX];
   assign grant_o      = grant_q;

   // Arbitration FSM next state, grant and starvation-counter updates.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         starve_d[i] = starve_q[i];
      end
      case (state_q)
         ST_ARB: begin
            if (|s_axis_tvalid) begin
               grant_d = win_oh;
               state_d = ST_XFER;
               for (int i = 0; i < NUM_SRC; i++) begin
                  if (win_oh[i]) begin
                     starve_d[i] = '0;
                  end else if (s_axis_tvalid[i] && (starve_q[i] < StarveMax)) begin
                     starve_d[i] = starve_q[i] + CntW'(1);
                  end
               end
            end
         end
         ST_XFER: begin
            // Grant is held until the packet's last beat has been accepted.
            if (last_beat) begin
               state_d = ST_ARB;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_ARB;
            grant_d = '0;
         end
      endcase
   end

   // FSM state and grant registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_ARB;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Per-source starvation counter registers.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_starve
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            starve_q[gi] <= '0;
         end else begin
            starve_q[gi] <= starve_d[gi];
         end
      end
   end

   pcie_fc_update_timer #(
      .UPDATE_PERIOD (UPDATE_PERIOD)
   ) u_fc_timer (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .fc_init_done_i  (fc_init_done_i),
      .fc_last_beat_i  (fc_last_beat),
      .update_fc_req_o (update_fc_req_o)
   );

`ifdef DLLP_ARB_STATS_EN
   // Completed-packet counters, one per source, wrapping naturally.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stats
      logic [DllpStatsWidth-1:0] pkt_cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            pkt_cnt_q <= '0;
         end else if (last_beat && grant_q[gi]) begin
            pkt_cnt_q <= pkt_cnt_q + DllpStatsWidth'(1);
         end
      end
      assign stats_o[gi*DllpStatsWidth +: DllpStatsWidth] = pkt_cnt_q;
   end
`endif

endmodule

// File: tb/tb_pcie_dllp_tx_arbiter.sv
// Self-checking bench for pcie_dllp_tx_arbiter: queue-driven sources, a
// packet-level reference model compared every cycle, and directed scenarios.
module tb_pcie_dllp_tx_arbiter;
   import pcie_datalink_pkg::*;

   localparam int          DW  = 32;
   localparam int          KW  = 4;
   localparam int          UW  = 3;
   localparam int          NS  = 3;
   localparam int          SL  = 4;
   localparam int          FCI = 1;
   localparam logic [15:0] UP  = 16'd8;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NS*DW-1:0] s_tdata = '0;
   logic [NS*KW-1:0] s_tkeep = '0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic [NS*UW-1:0] s_tuser = '0;
   logic [NS-1:0]    s_tready;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic             m_tvalid;
   logic             m_tlast;
   logic [UW-1:0]    m_tuser;
   logic             m_tready = 1'b0;
   logic             fc_init = 1'b0;
   logic             update_req;
   logic [NS-1:0]    grant;
`ifdef DLLP_ARB_STATS_EN
   logic [NS*16-1:0] stats;
`endif

   always #5 clk = ~clk;

   pcie_dllp_tx_arbiter #(
      .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .USER_WIDTH (UW), .NUM_SRC (NS),
      .STARVE_LIMIT (SL), .FC_SRC_IDX (FCI), .UPDATE_PERIOD (UP)
   ) dut (
      .clk_i (clk), .rst_ni (rst_n),
      .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (s_tvalid),
      .s_axis_tlast (s_tlast), .s_axis_tuser (s_tuser), .s_axis_tready (s_tready),
      .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tvalid (m_tvalid),
      .m_axis_tlast (m_tlast), .m_axis_tuser (m_tuser), .m_axis_tready (m_tready),
      .fc_init_done_i (fc_init), .update_fc_req_o (update_req), .grant_o (grant)
`ifdef DLLP_ARB_STATS_EN
      , .stats_o (stats)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Stimulus state
   beat_t src_q [NS][$];
   bit    rdy_pat [$];
   int    valid_pct = 100;
   int    ready_pct = 100;
   bit    fc_req = 1'b0;
   int    pushed_pkts = 0;
   logic [DW-1:0] pushed_d [$];
   int    cyc = 0;

   // Model state and logs
   int    m_grant = -1;
   int    m_starve [NS];
   int    m_timer = 0;
   bit    pop_req [NS];
   int    done_pkts = 0;
   int    arb_src [$];
   int    arb_cyc [$];
   int    arb_starve2 [$];
   int    beat_cyc [$];
   logic [DW-1:0] beat_d [$];
   int    pulse_cyc [$];
   int    fc_last_cyc [$];
   int    fc_last_timer [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Input driver: updates all DUT inputs shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      fc_init = fc_req;
      if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
      else m_tready = ($urandom_range(99) < valid_pct_r(ready_pct));
      for (int i = 0; i < NS; i++) begin
         beat_t b;
         if (pop_req[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_tvalid[i] = ($urandom_range(99) < valid_pct_r(valid_pct));
         end else begin
            b.d = $urandom; b.k = KW'($urandom); b.u = UW'($urandom); b.l = 1'($urandom);
            s_tvalid[i] = 1'b0;
         end
         s_tdata[i*DW +: DW] = b.d;
         s_tkeep[i*KW +: KW] = b.k;
         s_tuser[i*UW +: UW] = b.u;
         s_tlast[i]          = b.l;
      end
   end

   function automatic int unsigned valid_pct_r(input int p);
      return int'(p) < 0 ? 0 : p;
   endfunction

   // Reference model: packet-level arbitration/timer rules, checked every cycle.
   always @(negedge clk) begin
      logic [NS-1:0] eg, etr;
      logic [DW-1:0] ed;
      logic [KW-1:0] ek;
      logic [UW-1:0] eu;
      logic ev, el, ep, bt, fcl;
      int cand [$];
      int w;
      if (!rst_n) begin
         m_grant = -1;
         m_timer = 0;
         for (int i = 0; i < NS; i++) begin m_starve[i] = 0; pop_req[i] = 1'b0; end
      end else begin
         eg = '0; etr = '0; ed = '0; ek = '0; eu = '0; ev = 1'b0; el = 1'b0;
         if (m_grant >= 0) begin
            eg[m_grant]  = 1'b1;
            etr[m_grant] = m_tready;
            ed = s_tdata[m_grant*DW +: DW];
            ek = s_tkeep[m_grant*KW +: KW];
            eu = s_tuser[m_grant*UW +: UW];
            ev = s_tvalid[m_grant];
            el = s_tlast[m_grant];
         end
         bt  = ev && m_tready;
         fcl = bt && el && (m_grant == FCI);
         ep  = fc_init && (m_timer == int'(UP) - 1) && !fcl;
         chk("grant_o", grant, eg);
         chk("s_tready", s_tready, etr);
         chk("m_tvalid", m_tvalid, ev);
         chk("m_tlast", m_tlast, el);
         chk("m_tdata", m_tdata, ed);
         chk("m_tkeep", m_tkeep, ek);
         chk("m_tuser", m_tuser, eu);
         chk("update_fc_req", update_req, ep);
         if (ep) pulse_cyc.push_back(cyc);
         for (int i = 0; i < NS; i++) pop_req[i] = bt && (m_grant == i);
         if (bt) begin beat_cyc.push_back(cyc); beat_d.push_back(ed); end
         if (fcl) begin fc_last_cyc.push_back(cyc); fc_last_timer.push_back(m_timer); end
         if (!fc_init || fcl || m_timer == int'(UP) - 1) m_timer = 0;
         else m_timer = m_timer + 1;
         if (m_grant < 0) begin
            if (s_tvalid != '0) begin
               cand.delete();
               for (int i = 0; i < NS; i++) if (s_tvalid[i] && m_starve[i] >= SL) cand.push_back(i);
               if (cand.size() == 0)
                  for (int i = 0; i < NS; i++) if (s_tvalid[i]) cand.push_back(i);
               w = cand[0];
               for (int i = 0; i < NS; i++) begin
                  if (i == w) m_starve[i] = 0;
                  else if (s_tvalid[i]) m_starve[i] = (m_starve[i] + 1 > SL) ? SL : m_starve[i] + 1;
               end
               m_grant = w;
               arb_src.push_back(w);
               arb_cyc.push_back(cyc);
               arb_starve2.push_back(m_starve[2]);
            end
         end else if (bt && el) begin
            $display("pkt done src=%0d cyc=%0d", m_grant, cyc);
            m_grant = -1;
            done_pkts++;
         end
      end
   end

   task automatic push_pkt(input int src, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         beat_t bb;
         bb.d = $urandom; bb.k = KW'($urandom); bb.u = UW'($urandom);
         bb.l = (b == nbeats - 1);
         src_q[src].push_back(bb);
         pushed_d.push_back(bb.d);
      end
      pushed_pkts++;
   endtask

   task automatic clear_logs();
      arb_src.delete(); arb_cyc.delete(); arb_starve2.delete();
      beat_cyc.delete(); beat_d.delete(); pulse_cyc.delete();
      fc_last_cyc.delete(); fc_last_timer.delete(); pushed_d.delete();
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (n < budget && !(queues_empty() && m_grant < 0)) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_timeout"}, (n < budget), 1'b1);
   endtask

   task automatic wait_grant(input int g, input int budget, input string tag);
      int n = 0;
      while (n < budget && m_grant != g) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_grant_timeout"}, (n < budget), 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nxt;
      int rel_cyc;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 3'b000);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_s_tready", s_tready, 3'b000);
      chk("rst_m_tdata", m_tdata, 32'h0);
      chk("rst_update", update_req, 1'b0);
      @(posedge clk); #2 rst_n = 1'b1;

      // Single 2-beat packet from src1
      clear_logs();
      @(posedge clk);
      push_pkt(1, 2);
      @(negedge clk);
      @(negedge clk);
      chk("p1_grant_010", grant, 3'b010);
      wait_idle(50, "p1");
      @(negedge clk);
      chk("p1_grant_idle", grant, 3'b000);
      chk("p1_winner", arb_src[0], 1);
      chk("p1_first_beat_lat", beat_cyc[0] - arb_cyc[0], 1);
      chk("p1_beats_consecutive", beat_cyc[1] - beat_cyc[0], 1);

      // src0 and src2 together
      clear_logs();
      @(posedge clk);
      push_pkt(0, 1);
      push_pkt(2, 1);
      wait_idle(50, "p2");
      chk("p2_first", arb_src[0], 0);
      chk("p2_second", arb_src[1], 2);
      chk("p2_starve2", arb_starve2[0], 1);
      chk("p2_bubble", beat_cyc[1] - beat_cyc[0], 2);

      // src0 streaming, src2 starved
      clear_logs();
      @(posedge clk);
      for (int i = 0; i < 6; i++) push_pkt(0, 1);
      push_pkt(2, 1);
      wait_idle(100, "p3");
      chk("p3_arb_count", arb_src.size(), 7);
      chk("p3_arb4_src0", arb_src[3], 0);
      chk("p3_arb5_src2", arb_src[4], 2);

      // src0 arrives mid src1 packet, ready toggling
      clear_logs();
      @(posedge clk);
      rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      push_pkt(1, 4);
      wait_grant(1, 20, "p4");
      push_pkt(0, 1);
      wait_idle(100, "p4");
      chk("p4_arb_first", arb_src[0], 1);
      chk("p4_arb_second", arb_src[1], 0);
      chk("p4_beat_count", beat_d.size(), 5);
      for (int i = 0; i < 5; i++) chk("p4_beat_data", beat_d[i], pushed_d[i]);

      // UpdateFC timer
      clear_logs();
      @(posedge clk);
      fc_req = 1'b1;
      repeat (40) @(posedge clk);
      chk("p5_pulse_count", pulse_cyc.size() >= 4, 1'b1);
      for (int i = 0; i < 3; i++) chk("p5_period", pulse_cyc[i+1] - pulse_cyc[i], 8);
      nxt = 0;
      while (nxt < 20 && m_timer != 6) begin @(posedge clk); nxt++; end
      chk("p5_align_timeout", (nxt < 20), 1'b1);
      push_pkt(1, 1);
      wait_idle(50, "p5");
      repeat (20) @(posedge clk);
      chk("p5_fc_last_timer", fc_last_timer[0], 7);
      nxt = -1;
      for (int i = 0; i < pulse_cyc.size(); i++) begin
         chk("p5_suppressed", (pulse_cyc[i] == fc_last_cyc[0]), 1'b0);
         if (nxt < 0 && pulse_cyc[i] > fc_last_cyc[0]) nxt = pulse_cyc[i];
      end
      chk("p5_restart", nxt - fc_last_cyc[0], 8);

      // Randomized traffic
      clear_logs();
      valid_pct = 70;
      ready_pct = 70;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         if ($urandom_range(99) < 12) begin
            int s;
            s = int'($urandom_range(NS - 1));
            if (src_q[s].size() < 8) push_pkt(s, int'($urandom_range(1, 4)));
         end
         if ($urandom_range(99) < 2) fc_req = ~fc_req;
      end
      valid_pct = 100;
      ready_pct = 100;
      wait_idle(500, "p6");
      chk("pkt_count", done_pkts, pushed_pkts);

      // Reset mid-transfer
      fc_req = 1'b1;
      @(posedge clk);
      push_pkt(2, 4);
      wait_grant(2, 20, "p7");
      @(posedge clk);
      #3;
      chk("p7_active_before", m_tvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("p7_grant", grant, 3'b000);
      chk("p7_m_tvalid", m_tvalid, 1'b0);
      chk("p7_m_tlast", m_tlast, 1'b0);
      chk("p7_s_tready", s_tready, 3'b000);
      chk("p7_m_tdata", m_tdata, 32'h0);
      chk("p7_update", update_req, 1'b0);
      for (int i = 0; i < NS; i++) src_q[i].delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      rel_cyc = cyc;
      clear_logs();
      repeat (20) @(posedge clk);
      chk("p7_idle_after", grant, 3'b000);
      chk("p7_first_pulse", pulse_cyc[0] - rel_cyc, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
